multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Multi-cycle sequencer for the 16-bit DataPath: replaces the single-cycle ControlUnit decode with an FSM that steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK over several Clock cycles. It shares one unified memory port between instruction fetch and data access, stalling on a MemReady handshake. It sits beside DataPath inside CPU, takes opcode from the instruction register, and drives all datapath enables and mux selects.

Parameters:
PC_INC, 2, byte increment added to PC on fetch (16-bit words, byte-addressed)
OPC_W, 4, opcode width

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high; forces FSM to FETCH and all outputs to 0
opcode  input  4  IR[15:12], valid from DECODE onward
Zero  input  1  ALU zero flag, used in BEQ EXECUTE
MemReady  input  1  memory completes current MemRead/MemWrite this cycle
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemRead  output  1  memory read request, held until MemReady
MemWrite  output  1  memory write request, held until MemReady
IrWrite  output  1  load IR
PcWrite  output  1  unconditional PC load
RegDst  output  1  write reg select: 1=rd (R-type), 0=rt
MemToReg  output  1  writeback source: 1=MDR, 0=ALUOut
RegWrite  output  1  register file write enable
AluSrcA  output  1  0=PC, 1=reg A
AluSrcB  output  2  00=reg B, 01=PC_INC, 10=sign-ext imm
AluOp  output  2  00=add, 01=sub, 10=funct-decoded
PcSource  output  1  0=ALU result, 1=ALUOut (branch target)
Halted  output  1  sticky; FSM in HALT
IllegalOp  output  1  sticky; HALT entered via undefined opcode

Behaviour:
- Opcodes: 0000 R-type, 0001 ADDI, 0010 LW, 0011 SW, 0100 BEQ, 1111 HALT; all others illegal.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. On Reset, state=FETCH and every output=0, including Halted and IllegalOp.
- FETCH: IorD=0, MemRead=1. AluSrcA=0, AluSrcB=01, AluOp=00, PcSource=0.
  - If MemReady=0, stay in FETCH; IrWrite=0 and PcWrite=0.
  - If MemReady=1, IrWrite=1 and PcWrite=1 in that same cycle, then go to DECODE.
- DECODE: AluSrcA=0, AluSrcB=10, AluOp=00 (branch target precomputed into ALUOut).
  - Next state EXEC for opcodes 0000-0100; HALT for 1111.
  - Next state HALT with IllegalOp set for all other opcodes.
- EXEC:
  - R-type: AluSrcA=1, AluSrcB=00, AluOp=10; next WB.
  - ADDI, LW, SW: AluSrcA=1, AluSrcB=10, AluOp=00; ADDI goes to WB, LW and SW go to MEM.
  - BEQ: AluSrcA=1, AluSrcB=00, AluOp=01, PcSource=1, PcWrite=Zero; next FETCH.
- MEM: IorD=1. LW asserts MemRead; SW asserts MemWrite. Stay in MEM while MemReady=0. When MemReady=1: LW goes to WB, SW goes to FETCH.
- WB: RegWrite=1 for one cycle; next FETCH.
  - R-type: RegDst=1, MemToReg=0.
  - ADDI: RegDst=0, MemToReg=0.
  - LW: RegDst=0, MemToReg=1.
- Latency with MemReady always 1: R-type 4, ADDI 4, LW 5, SW 4, BEQ 3 cycles.
- Each memory wait cycle adds one cycle. MemRead/MemWrite never drop mid-wait.
- HALT: all enables 0, Halted=1. Only Reset exits HALT.
- Reset mid-wait aborts the access asynchronously. No partial RegWrite or PcWrite is allowed.
- Control outputs are combinational from the state register and latched opcode. IrWrite, PcWrite, and the state transitions out of wait states also depend on MemReady (Mealy).

Optional Feature:
PERF_CNT_EN: when defined, adds two 16-bit outputs, RetiredCnt and CycleCnt.
- RetiredCnt increments on every instruction's final cycle: WB exit, SW MEM exit, BEQ EXEC.
- CycleCnt increments on every non-HALT cycle.
- Both reset to 0 and wrap at 0xFFFF->0x0000.
- When undefined, neither the ports nor the counters exist; behaviour is otherwise identical.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode constants;
  - state enum (3-bit encoding);
  - AluOp codes;
  - AluSrcB select codes;
  - PC_INC default.
- One natural sub-module: multicycle_ctrl_decode. It is purely combinational, maps (state, opcode, Zero, MemReady) to control outputs, and is used by the FSM top.

Test Plan:
1. Reset high mid-FETCH with MemRead=1, then release -> all outputs 0 during Reset; MemRead=1 and IorD=0 on the first cycle after release.
2. R-type 0000 with MemReady=1 -> 4 cycles. RegWrite=1, RegDst=1, MemToReg=0 only in cycle 4; back to FETCH in cycle 5.
3. LW 0010 with MemReady low for 3 cycles in MEM -> MemRead and IorD=1 held for 4 cycles; WB RegWrite=1, MemToReg=1; total 8 cycles.
4. BEQ 0100 with Zero=1, then repeated with Zero=0 -> PcWrite=1, PcSource=1 in the EXEC cycle for the first case and PcWrite=0 for the second; 3 cycles each.
5. Opcode 1010 -> HALT after DECODE with IllegalOp=1 and Halted=1; stays halted for 20 cycles with MemReady toggling; Reset clears both.
6. PERF_CNT_EN defined, SW then HALT (1111), MemReady=1 -> RetiredCnt=1, CycleCnt=6 once HALT is entered.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU controller: opcodes, FSM states,
// ALU operation / operand-select codes and the control-word layout.
package cpu_ctrl_pkg;

  localparam int OPC_WIDTH  = 4;
  localparam int PC_INC_DEF = 2;

  localparam logic [OPC_WIDTH-1:0] OPC_RTYPE = 4'h0;
  localparam logic [OPC_WIDTH-1:0] OPC_ADDI  = 4'h1;
  localparam logic [OPC_WIDTH-1:0] OPC_LW    = 4'h2;
  localparam logic [OPC_WIDTH-1:0] OPC_SW    = 4'h3;
  localparam logic [OPC_WIDTH-1:0] OPC_BEQ   = 4'h4;
  localparam logic [OPC_WIDTH-1:0] OPC_HALT  = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_REG = 2'b00,
    SRCB_INC = 2'b01,
    SRCB_IMM = 2'b10
  } alu_src_b_t;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    logic       pc_source;
  } ctrl_t;

  // Opcodes that proceed to EXEC; HALT and everything above BEQ do not.
  function automatic logic opc_is_exec(input logic [OPC_WIDTH-1:0] opc);
    return (opc <= OPC_BEQ);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational control-word decode from (state, opcode, Zero, MemReady).
// Halted/IllegalOp and reset gating are handled by the FSM top.
module multicycle_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t                 state,
  input  logic [OPC_WIDTH-1:0]   opc,
  input  logic                   zero,
  input  logic                   mem_ready,
  output ctrl_t                  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_INC;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        // ALU computes PC + imm so the branch target sits in ALUOut for EXEC.
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        case (opc)
          OPC_RTYPE: begin
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALU_FUNCT;
          end
          OPC_BEQ: begin
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALU_SUB;
            ctrl.pc_source = 1'b1;
            ctrl.pc_write  = zero;
          end
          default: begin
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
          end
        endcase
      end
      ST_MEM: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_read  = (opc == OPC_LW);
        ctrl.mem_write = (opc == OPC_SW);
      end
      ST_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = (opc == OPC_RTYPE);
        ctrl.mem_to_reg = (opc == OPC_LW);
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port.
// Optional build macro PERF_CNT_EN adds RetiredCnt/CycleCnt counters.
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_INC = PC_INC_DEF,
  parameter int OPC_W  = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IrWrite,
  output logic             PcWrite,
  output logic             RegDst,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             AluSrcA,
  output logic [1:0]       AluSrcB,
  output logic [1:0]       AluOp,
  output logic             PcSource,
  output logic             Halted,
  output logic             IllegalOp
`ifdef PERF_CNT_EN
  ,
  output logic [15:0]      RetiredCnt,
  output logic [15:0]      CycleCnt
`endif
);

  if (OPC_W != OPC_WIDTH || PC_INC < 1) begin : g_cfg_check
    $error("multicycle_controller: OPC_W must be 4 and PC_INC positive");
  end

  state_t           state_q, state_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic             illegal_q, illegal_d;
  logic [OPC_W-1:0] opc_cur;
  ctrl_t            ctrl_raw, ctrl_out;

  // IR becomes valid in DECODE; later states use the copy captured there.
  assign opc_cur = (state_q == ST_DECODE) ? opcode : opc_q;

  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_FETCH: if (MemReady) state_d = ST_DECODE;
      ST_DECODE: begin
        opc_d = opcode;
        if (opc_is_exec(opcode)) begin
          state_d = ST_EXEC;
        end else begin
          state_d   = ST_HALT;
          illegal_d = (opcode != OPC_HALT);
        end
      end
      ST_EXEC: begin
        case (opc_q)
          OPC_RTYPE, OPC_ADDI: state_d = ST_WB;
          OPC_LW, OPC_SW:      state_d = ST_MEM;
          default:             state_d = ST_FETCH;
        endcase
      end
      ST_MEM: if (MemReady) state_d = (opc_q == OPC_LW) ? ST_WB : ST_FETCH;
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_FETCH;
      opc_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      illegal_q <= illegal_d;
    end
  end

  multicycle_ctrl_decode u_decode (
    .state     (state_q),
    .opc       (opc_cur),
    .zero      (Zero),
    .mem_ready (MemReady),
    .ctrl      (ctrl_raw)
  );

  // Reset must silence the Mealy outputs immediately, including FETCH's MemRead.
  assign ctrl_out  = Reset ? '0 : ctrl_raw;

  assign IorD      = ctrl_out.iord;
  assign MemRead   = ctrl_out.mem_read;
  assign MemWrite  = ctrl_out.mem_write;
  assign IrWrite   = ctrl_out.ir_write;
  assign PcWrite   = ctrl_out.pc_write;
  assign RegDst    = ctrl_out.reg_dst;
  assign MemToReg  = ctrl_out.mem_to_reg;
  assign RegWrite  = ctrl_out.reg_write;
  assign AluSrcA   = ctrl_out.alu_src_a;
  assign AluSrcB   = ctrl_out.alu_src_b;
  assign AluOp     = ctrl_out.alu_op;
  assign PcSource  = ctrl_out.pc_source;
  assign Halted    = !Reset && (state_q == ST_HALT);
  assign IllegalOp = !Reset && illegal_q;

`ifdef PERF_CNT_EN
  logic [15:0] retired_q, retired_d;
  logic [15:0] cycle_q, cycle_d;
  logic        retire;

  always_comb begin
    retire = (state_q == ST_WB)
          || (state_q == ST_EXEC && opc_q == OPC_BEQ)
          || (state_q == ST_MEM && opc_q == OPC_SW && MemReady);
    retired_d = retire ? retired_q + 16'd1 : retired_q;
    cycle_d   = (state_q != ST_HALT) ? cycle_q + 16'd1 : cycle_q;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      retired_q <= '0;
      cycle_q   <= '0;
    end else begin
      retired_q <= retired_d;
      cycle_q   <= cycle_d;
    end
  end

  assign RetiredCnt = retired_q;
  assign CycleCnt   = cycle_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed vector table, hand sequences for
// HALT/reset corners, and a randomized run against a phase-queue model.
module tb_multicycle_controller;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       IorD, MemRead, MemWrite, IrWrite, PcWrite, RegDst, MemToReg;
  logic       RegWrite, AluSrcA, PcSource, Halted, IllegalOp;
  logic [1:0] AluSrcB, AluOp;
`ifdef PERF_CNT_EN
  logic [15:0] RetiredCnt, CycleCnt;
`endif

  multicycle_controller dut (
    .Clock(Clock), .Reset(Reset), .opcode(opcode), .Zero(Zero), .MemReady(MemReady),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IrWrite(IrWrite),
    .PcWrite(PcWrite), .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp), .PcSource(PcSource),
    .Halted(Halted), .IllegalOp(IllegalOp)
`ifdef PERF_CNT_EN
    , .RetiredCnt(RetiredCnt), .CycleCnt(CycleCnt)
`endif
  );

  always #5 Clock = ~Clock;

  // {IorD,MemRead,MemWrite,IrWrite,PcWrite,RegDst,MemToReg,RegWrite,
  //  AluSrcA,AluSrcB[1:0],AluOp[1:0],PcSource,Halted,IllegalOp}
  logic [15:0] act;
  assign act = {IorD, MemRead, MemWrite, IrWrite, PcWrite, RegDst, MemToReg, RegWrite,
                AluSrcA, AluSrcB, AluOp, PcSource, Halted, IllegalOp};

  localparam logic [15:0] E_RST    = 16'h0000;
  localparam logic [15:0] E_FWAIT  = 16'h4020;
  localparam logic [15:0] E_FDONE  = 16'h5820;
  localparam logic [15:0] E_DEC    = 16'h0040;
  localparam logic [15:0] E_EX_R   = 16'h0090;
  localparam logic [15:0] E_EX_I   = 16'h00C0;
  localparam logic [15:0] E_BEQ_T  = 16'h088C;
  localparam logic [15:0] E_BEQ_N  = 16'h008C;
  localparam logic [15:0] E_MEM_LW = 16'hC000;
  localparam logic [15:0] E_MEM_SW = 16'hA000;
  localparam logic [15:0] E_WB_R   = 16'h0500;
  localparam logic [15:0] E_WB_I   = 16'h0100;
  localparam logic [15:0] E_WB_LW  = 16'h0300;
  localparam logic [15:0] E_HALT   = 16'h0002;
  localparam logic [15:0] E_ILL    = 16'h0003;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  opc;
    logic        zero;
    logic        rdy;
    logic [15:0] exp;
  } vec_t;

  typedef enum {PH_FETCH, PH_DECODE, PH_EXEC, PH_MEM, PH_WB} ph_t;

  vec_t tbl[35];

  function automatic vec_t mk(input logic r, input logic [3:0] o, input logic z,
                              input logic m, input logic [15:0] e);
    vec_t v;
    v.rst = r; v.opc = o; v.zero = z; v.rdy = m; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read at the falling edge.
  task automatic drive(input logic r, input logic [3:0] o, input logic z, input logic m);
    @(posedge Clock);
    #1;
    Reset = r; opcode = o; Zero = z; MemReady = m;
    @(negedge Clock);
  endtask

  // Expected outputs for one cycle of an instruction step, straight from the step tables.
  function automatic logic [15:0] model_out(input ph_t ph, input logic [3:0] op,
                                            input logic z, input logic rdy);
    case (ph)
      PH_FETCH:  return rdy ? E_FDONE : E_FWAIT;
      PH_DECODE: return E_DEC;
      PH_EXEC:   return (op == 4'h0) ? E_EX_R : (op == 4'h4) ? (z ? E_BEQ_T : E_BEQ_N) : E_EX_I;
      PH_MEM:    return (op == 4'h2) ? E_MEM_LW : E_MEM_SW;
      default:   return (op == 4'h0) ? E_WB_R : (op == 4'h1) ? E_WB_I : E_WB_LW;
    endcase
  endfunction

  initial begin
    ph_t         q[$];
    ph_t         ph;
    logic [3:0]  op;
    logic [3:0]  opin;
    logic        rdy;
    logic        z;
    int          guard;
    int          cycles_m;
    int          retired_m;

    // Reset mid-FETCH, R-type, LW with 3 waits, BEQ taken/not, SW with a wait, ADDI, illegal.
    tbl[0]  = mk(0, 4'h0, 0, 0, E_FWAIT);
    tbl[1]  = mk(1, 4'h0, 0, 0, E_RST);
    tbl[2]  = mk(1, 4'h0, 0, 1, E_RST);
    tbl[3]  = mk(0, 4'h0, 0, 0, E_FWAIT);
    tbl[4]  = mk(0, 4'h0, 0, 1, E_FDONE);
    tbl[5]  = mk(0, 4'h0, 0, 1, E_DEC);
    tbl[6]  = mk(0, 4'h0, 1, 1, E_EX_R);
    tbl[7]  = mk(0, 4'h0, 0, 1, E_WB_R);
    tbl[8]  = mk(0, 4'h0, 0, 0, E_FWAIT);
    tbl[9]  = mk(0, 4'h0, 0, 1, E_FDONE);
    tbl[10] = mk(0, 4'h2, 0, 1, E_DEC);
    tbl[11] = mk(0, 4'h2, 0, 1, E_EX_I);
    tbl[12] = mk(0, 4'h2, 0, 0, E_MEM_LW);
    tbl[13] = mk(0, 4'h2, 0, 0, E_MEM_LW);
    tbl[14] = mk(0, 4'h2, 0, 0, E_MEM_LW);
    tbl[15] = mk(0, 4'h2, 0, 1, E_MEM_LW);
    tbl[16] = mk(0, 4'h2, 0, 1, E_WB_LW);
    tbl[17] = mk(0, 4'h0, 0, 1, E_FDONE);
    tbl[18] = mk(0, 4'h4, 1, 1, E_DEC);
    tbl[19] = mk(0, 4'h4, 1, 1, E_BEQ_T);
    tbl[20] = mk(0, 4'h0, 0, 1, E_FDONE);
    tbl[21] = mk(0, 4'h4, 0, 1, E_DEC);
    tbl[22] = mk(0, 4'h4, 0, 1, E_BEQ_N);
    tbl[23] = mk(0, 4'h0, 0, 1, E_FDONE);
    tbl[24] = mk(0, 4'h3, 0, 1, E_DEC);
    tbl[25] = mk(0, 4'h3, 0, 1, E_EX_I);
    tbl[26] = mk(0, 4'h3, 0, 0, E_MEM_SW);
    tbl[27] = mk(0, 4'h3, 0, 1, E_MEM_SW);
    tbl[28] = mk(0, 4'h0, 0, 1, E_FDONE);
    tbl[29] = mk(0, 4'h1, 0, 1, E_DEC);
    tbl[30] = mk(0, 4'h1, 0, 1, E_EX_I);
    tbl[31] = mk(0, 4'h1, 0, 1, E_WB_I);
    tbl[32] = mk(0, 4'h0, 0, 1, E_FDONE);
    tbl[33] = mk(0, 4'hA, 0, 1, E_DEC);
    tbl[34] = mk(0, 4'hA, 0, 1, E_ILL);

    repeat (2) @(posedge Clock);
    for (int i = 0; i < 35; i++) begin
      drive(tbl[i].rst, tbl[i].opc, tbl[i].zero, tbl[i].rdy);
      chk($sformatf("vec%0d", i), act, tbl[i].exp);
    end

    // Illegal HALT is sticky for 20 cycles of MemReady toggling; only Reset clears it.
    for (int i = 0; i < 20; i++) begin
      drive(0, 4'($urandom), 1'($urandom), 1'(i & 1));
      chk($sformatf("halt_hold%0d", i), act, E_ILL);
    end
    drive(1, 4'h0, 0, 1);
    chk("halt_reset", act, E_RST);
    drive(0, 4'h0, 0, 0);
    chk("halt_release", act, E_FWAIT);

`ifdef PERF_CNT_EN
    drive(1, 4'h0, 0, 1);
    drive(0, 4'h0, 0, 1); chk("sw_fetch", act, E_FDONE);
    drive(0, 4'h3, 0, 1); chk("sw_dec", act, E_DEC);
    drive(0, 4'h3, 0, 1); chk("sw_exec", act, E_EX_I);
    drive(0, 4'h3, 0, 1); chk("sw_mem", act, E_MEM_SW);
    drive(0, 4'h0, 0, 1); chk("hlt_fetch", act, E_FDONE);
    drive(0, 4'hF, 0, 1); chk("hlt_dec", act, E_DEC);
    drive(0, 4'hF, 0, 1); chk("hlt_state", act, E_HALT);
    chk("retired_cnt", RetiredCnt, 16'd1);
    chk("cycle_cnt", CycleCnt, 16'd6);
    drive(0, 4'hF, 0, 0);
    chk("cycle_cnt_frozen", CycleCnt, 16'd6);
`endif

    // Randomized legal instruction stream against the phase-queue model.
    drive(1, 4'h0, 0, 0);
    cycles_m  = 0;
    retired_m = 0;
    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 4));
      q.delete();
      q.push_back(PH_FETCH);
      q.push_back(PH_DECODE);
      q.push_back(PH_EXEC);
      if (op == 4'h2 || op == 4'h3) q.push_back(PH_MEM);
      if (op <= 4'h2) q.push_back(PH_WB);
      guard = 0;
      while (q.size() > 0) begin
        ph   = q[0];
        rdy  = ($urandom_range(0, 3) != 0);
        z    = 1'($urandom);
        opin = (ph == PH_FETCH) ? 4'($urandom) : op;
        drive(0, opin, z, rdy);
        chk($sformatf("rnd%0d_op%0h_ph%0d", n, op, ph), act, model_out(ph, op, z, rdy));
        cycles_m++;
        if (!((ph == PH_FETCH || ph == PH_MEM) && !rdy)) void'(q.pop_front());
        guard++;
        if (guard > 200) begin
          chk("rnd_guard", 16'(guard), 16'd0);
          q.delete();
        end
      end
      retired_m++;
    end
    drive(0, 4'h0, 0, 1); chk("rnd_hlt_fetch", act, E_FDONE);
    drive(0, 4'hF, 0, 1); chk("rnd_hlt_dec", act, E_DEC);
    drive(0, 4'h0, 0, 0); chk("rnd_hlt_state", act, E_HALT);
`ifdef PERF_CNT_EN
    chk("rnd_retired", RetiredCnt, 16'(retired_m));
    chk("rnd_cycles", CycleCnt, 16'(cycles_m + 2));
`endif

    // Random undefined opcode after a fresh reset.
    drive(1, 4'h0, 0, 0);
    chk("ill_reset", act, E_RST);
    op = 4'($urandom_range(5, 14));
    drive(0, 4'h0, 0, 1); chk("ill_fetch", act, E_FDONE);
    drive(0, op, 0, 1);   chk("ill_dec", act, E_DEC);
    for (int i = 0; i < 3; i++) begin
      drive(0, op, 1'($urandom), 1'($urandom));
      chk($sformatf("ill_halt%0d_op%0h", i, op), act, E_ILL);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
